// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared types and sizing for the song sequencer
// Holds the sequencer FSM state enum, ROM word field widths and the default
// song length. No ports.
package music_pkg;
    localparam int NOTES_PER_SONG_DEF = 32;
    localparam int NOTE_W_DEF         = 6;
    localparam int SONG_W             = 2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_ROM,
        LOAD,
        WAIT_DONE,
        ADVANCE,
        DONE
    } seq_state_e;

    // ROM word is {note, duration}, both note_w wide.
    function automatic int rom_word_w(input int note_w);
        return 2 * note_w;
    endfunction
endpackage

// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - song ROM and note player bundle
// Signals: rom_addr/rom_data (song ROM), new_note/note/duration/note_done
// (note player handshake), song_done (end-of-song pulse).
// master: sequencer side; slave: ROM + note player side.
interface note_sequencer_if
    import music_pkg::*;
#(
    parameter int NOTES_PER_SONG = NOTES_PER_SONG_DEF,
    parameter int NOTE_W         = NOTE_W_DEF
);
    localparam int ADDR_W = SONG_W + $clog2(NOTES_PER_SONG);

    logic [ADDR_W-1:0]             rom_addr;
    logic [rom_word_w(NOTE_W)-1:0] rom_data;
    logic                          new_note;
    logic [NOTE_W-1:0]             note;
    logic [NOTE_W-1:0]             duration;
    logic                          note_done;
    logic                          song_done;

    modport master (
        output rom_addr, new_note, note, duration, song_done,
        input  rom_data, note_done
    );

    modport slave (
        input  rom_addr, new_note, note, duration, song_done,
        output rom_data, note_done
    );
endinterface

// File: rtl/counter_n.sv
// rtl/counter_n.sv - generic up counter with enable and synchronous clear
// Ports: clk, reset (async, active-high), en (count up), clr (sync clear,
// wins over en), count (current value).
module counter_n #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - steps through a song ROM and hands notes to a player
// Ports: clk, reset (async, active-high), play (level, run/pause),
// reset_play (sync pulse, restart song), song (upper ROM address bits),
// bus (master side: rom_addr/rom_data, new_note/note/duration/note_done,
// song_done).
// Optional: SEQ_END_MARK_EN makes a duration=0 word end the song early.
module note_sequencer
    import music_pkg::*;
#(
    parameter int NOTES_PER_SONG = NOTES_PER_SONG_DEF,
    parameter int NOTE_W         = NOTE_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              reset_play,
    input  logic [SONG_W-1:0] song,
    note_sequencer_if.master  bus
);
    localparam int                IDX_W    = $clog2(NOTES_PER_SONG);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTES_PER_SONG - 1);

    seq_state_e        state_q, state_d;
    logic              new_note_q, new_note_d;
    logic              song_done_q, song_done_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [NOTE_W-1:0] duration_q, duration_d;

    logic [IDX_W-1:0]  note_idx;
    logic              idx_en;
    logic              idx_clr;
    logic              end_mark;
    logic [NOTE_W-1:0] rom_note;
    logic [NOTE_W-1:0] rom_dur;

    assign {rom_note, rom_dur} = bus.rom_data;

`ifdef SEQ_END_MARK_EN
    assign end_mark = (rom_dur == '0);
`else
    assign end_mark = 1'b0;
`endif

    counter_n #(
        .WIDTH (IDX_W)
    ) u_note_idx (
        .clk   (clk),
        .reset (reset),
        .en    (idx_en),
        .clr   (idx_clr),
        .count (note_idx)
    );

    always_comb begin
        state_d     = state_q;
        new_note_d  = 1'b0;
        song_done_d = 1'b0;
        note_d      = note_q;
        duration_d  = duration_q;
        idx_en      = 1'b0;
        idx_clr     = 1'b0;

        if (reset_play) begin
            // Restart wins over everything, including a coincident note_done.
            state_d    = IDLE;
            note_d     = '0;
            duration_d = '0;
            idx_clr    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (play) state_d = FETCH;
                end
                FETCH: begin
                    state_d = WAIT_ROM;
                end
                WAIT_ROM: begin
                    // ROM word is valid now; capture it so note/duration and
                    // the new_note pulse are registered during LOAD. An end
                    // mark leaves the previous note held and pulses nothing.
                    state_d = LOAD;
                    if (!end_mark) begin
                        note_d     = rom_note;
                        duration_d = rom_dur;
                        new_note_d = 1'b1;
                    end
                end
                LOAD: begin
                    if (new_note_q) begin
                        state_d = WAIT_DONE;
                    end else begin
                        state_d     = DONE;
                        song_done_d = 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.note_done) state_d = ADVANCE;
                end
                ADVANCE: begin
                    // The last slot never increments; it returns to 0 via DONE.
                    if (note_idx == LAST_IDX) begin
                        state_d     = DONE;
                        song_done_d = 1'b1;
                    end else if (play) begin
                        idx_en  = 1'b1;
                        state_d = FETCH;
                    end
                end
                DONE: begin
                    idx_clr = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
            note_q      <= '0;
            duration_q  <= '0;
        end else begin
            state_q     <= state_d;
            new_note_q  <= new_note_d;
            song_done_q <= song_done_d;
            note_q      <= note_d;
            duration_q  <= duration_d;
        end
    end

    assign bus.rom_addr  = {song, note_idx};
    assign bus.new_note  = new_note_q;
    assign bus.song_done = song_done_q;
    assign bus.note      = note_q;
    assign bus.duration  = duration_q;
endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - self-checking bench for note_sequencer
module tb_note_sequencer;
    import music_pkg::*;

    localparam int NPS = 32;
    localparam int NW  = 6;
    localparam int AW  = 7;

    typedef struct packed {
        logic          is_done;
        logic [NW-1:0] note;
        logic [NW-1:0] dur;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       play = 1'b0;
    logic       reset_play = 1'b0;
    logic [1:0] song = 2'd0;
    logic       nd_auto = 1'b0;
    logic       nd_man = 1'b0;
    logic       auto_play = 1'b0;

    logic [2*NW-1:0] rom [128];
    ev_t             exp_q[$];
    int              n_cmp = 0;
    int              n_bad = 0;
    int              n_notes = 0;
    int              n_done = 0;
    logic [NW-1:0]   held_note;
    logic [NW-1:0]   held_dur;

    note_sequencer_if #(.NOTES_PER_SONG(NPS), .NOTE_W(NW)) bus ();

    note_sequencer #(.NOTES_PER_SONG(NPS), .NOTE_W(NW)) dut (
        .clk        (clk),
        .reset      (reset),
        .play       (play),
        .reset_play (reset_play),
        .song       (song),
        .bus        (bus)
    );

    assign bus.note_done = nd_auto | nd_man;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Expected events for playing a whole song from slot 0.
    task automatic push_song(input int s);
        for (int i = 0; i < NPS; i++) begin
            logic [2*NW-1:0] w;
            w = rom[s*NPS + i];
`ifdef SEQ_END_MARK_EN
            if (w[NW-1:0] == '0) break;
`endif
            exp_q.push_back({1'b0, w});
        end
        exp_q.push_back({1'b1, {(2*NW){1'b0}}});
    endtask

    task automatic push_slots(input int s, input int first, input int last);
        for (int i = first; i <= last; i++) exp_q.push_back({1'b0, rom[s*NPS + i]});
    endtask

    task automatic wait_new_note(input int max, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (bus.new_note) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_seen"}, 32'(seen), 1);
    endtask

    task automatic wait_empty(input int max, input string name);
        for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin : rom_model
        logic [AW-1:0] a;
        bus.rom_data = '0;
        forever begin
            @(posedge clk);
            a = bus.rom_addr;
            #1 bus.rom_data = rom[a];
        end
    end

    initial begin : player
        forever begin
            @(negedge clk);
            if (auto_play && bus.new_note) begin
                repeat (4) @(negedge clk);
                #1 nd_auto = 1'b1;
                @(negedge clk);
                #1 nd_auto = 1'b0;
            end
        end
    end

    initial begin : compare
        logic rp_edge;
        ev_t  e;
        held_note = '0;
        held_dur  = '0;
        forever begin
            @(posedge clk);
            rp_edge = reset_play;
            @(negedge clk);
            if (reset || rp_edge) begin
                check("cleared_outputs", {bus.new_note, bus.song_done, bus.note, bus.duration}, 0);
                held_note = '0;
                held_dur  = '0;
            end else begin
                if (bus.new_note) begin
                    check("new_note_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("event_is_note", 32'(e.is_done), 0);
                        check("note", bus.note, e.note);
                        check("duration", bus.duration, e.dur);
                    end
                    held_note = bus.note;
                    held_dur  = bus.duration;
                    n_notes++;
                end else begin
                    check("note_held", {bus.note, bus.duration}, {held_note, held_dur});
                end
                if (bus.song_done) begin
                    check("song_done_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("event_is_done", 32'(e.is_done), 1);
                    end
                    n_done++;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        // Each word identifies its own address: note = addr[5:0], dur = addr[6:2]+1.
        for (int a = 0; a < 128; a++) rom[a] = {6'(a), 6'((a >> 2) + 1)};
        rom[0]  = {6'd5, 6'd10};
        rom[36] = {6'd36, 6'd0};

        // Reset state.
        song = 2'd2;
        tick();
        check("reset_outputs", {bus.new_note, bus.song_done, bus.note, bus.duration}, 0);
        check("reset_rom_addr", bus.rom_addr, 64);

        // First note latency from reset release.
        song = 2'd0;
        exp_q.push_back({1'b0, 6'd5, 6'd10});
        tick();
        reset = 1'b0;
        play  = 1'b1;
        @(posedge clk); #1;
        check("c1_rom_addr", bus.rom_addr, 0);
        check("c1_new_note", bus.new_note, 0);
        @(posedge clk); #1;
        check("c2_new_note", bus.new_note, 0);
        @(posedge clk); #1;
        check("c3_new_note", bus.new_note, 1);
        check("c3_note", bus.note, 5);
        check("c3_duration", bus.duration, 10);

        // Async reset while in LOAD clears outputs before the next edge.
        @(negedge clk);
        #1 reset = 1'b1;
        play = 1'b0;
        #1;
        check("async_reset_outputs", {bus.new_note, bus.song_done, bus.note, bus.duration}, 0);
        check("async_reset_rom_addr", bus.rom_addr, 0);
        tick();
        tick();
        reset = 1'b0;

        // No pulses while play stays low.
        repeat (6) tick();
        check("idle_no_pulse", {bus.new_note, bus.song_done}, 0);

        // Full song 2 with an automatic note player.
        song = 2'd2;
        n_notes = 0;
        n_done  = 0;
        push_song(2);
        auto_play = 1'b1;
        play = 1'b1;
        wait_empty(700, "song2");
        play = 1'b0;
        auto_play = 1'b0;
        check("song2_notes", n_notes, 32);
        check("song2_done", n_done, 1);
        repeat (4) tick();

        // Pause in slot 3, then resume.
        song = 2'd3;
        push_slots(3, 0, 4);
        play = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_new_note(20, "pause_slot");
            tick();
            tick();
            if (k == 3) play = 1'b0;
            nd_man = 1'b1;
            tick();
            nd_man = 1'b0;
        end
        repeat (5) tick();
        check("pause_rom_addr", bus.rom_addr, 99);
        check("pause_no_pulse", bus.new_note, 0);
        play = 1'b1;
        @(posedge clk); #1;
        check("resume_rom_addr", bus.rom_addr, 100);
        wait_new_note(20, "resume_slot4");
        tick();
        reset_play = 1'b1;
        play = 1'b0;
        tick();
        reset_play = 1'b0;
        check("pause_drained", exp_q.size(), 0);
        repeat (3) tick();

        // reset_play coincident with note_done at slot 7.
        song = 2'd2;
        n_done = 0;
        push_slots(2, 0, 7);
        play = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_new_note(20, "rp_slot");
            tick();
            tick();
            nd_man = 1'b1;
            if (k == 7) reset_play = 1'b1;
            tick();
            nd_man = 1'b0;
            reset_play = 1'b0;
        end
        check("rp_rom_addr", bus.rom_addr, 64);
        check("rp_outputs", {bus.new_note, bus.song_done, bus.note, bus.duration}, 0);
        push_slots(2, 0, 0);
        wait_new_note(20, "rp_restart");
        check("rp_restart_note", bus.note, 0);
        check("rp_restart_dur", bus.duration, 17);
        play = 1'b0;
        reset_play = 1'b1;
        tick();
        reset_play = 1'b0;
        check("rp_no_song_done", n_done, 0);
        repeat (3) tick();

        // Song 1 has a duration=0 word in slot 4.
        song = 2'd1;
        n_notes = 0;
        n_done  = 0;
        push_song(1);
        auto_play = 1'b1;
        play = 1'b1;
        wait_empty(700, "song1");
        play = 1'b0;
        auto_play = 1'b0;
`ifdef SEQ_END_MARK_EN
        check("song1_notes", n_notes, 4);
`else
        check("song1_notes", n_notes, 32);
`endif
        check("song1_done", n_done, 1);
        repeat (6) tick();

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter NOTES_PER_SONG, default 32: number of note slots per song (power of two; index width = log2).
REQ-002 Parameter NOTE_W, default 6: width of the note code and of the duration field.
REQ-003 Port clk, input, 1: 100 MHz system clock; all state on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port play, input, 1: level; 1 = sequencing allowed, 0 = paused.
REQ-006 Port reset_play, input, 1: one-cycle synchronous pulse; restarts the current song from slot 0.
REQ-007 Port song, input, 2: current song number, used as the upper ROM address bits.
REQ-008 Port rom_addr, output, 2+log2(NOTES_PER_SONG): song ROM address = {song, note_idx}.
REQ-009 Port rom_data, input, 2*NOTE_W: ROM word = {note, duration}; valid exactly 1 cycle after rom_addr changes.
REQ-010 Port new_note, output, 1: one-cycle pulse; note/duration valid to the note player.
REQ-011 Port note, output, NOTE_W: note code held from new_note until the next new_note.
REQ-012 Port duration, output, NOTE_W: duration held alongside note.
REQ-013 Port note_done, input, 1: one-cycle pulse from the note player; the current note has finished.
REQ-014 Port song_done, output, 1: one-cycle pulse; the last note of the song has completed.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, WAIT_ROM, LOAD, WAIT_DONE, ADVANCE, DONE.
REQ-016 IDLE -> FETCH SHALL occur when play=1; otherwise IDLE SHALL hold.
REQ-017 FETCH SHALL drive rom_addr={song,note_idx} and SHALL move to WAIT_ROM unconditionally.
REQ-018 WAIT_ROM -> LOAD SHALL be unconditional (ROM latency of 1 cycle).
REQ-019 LOAD SHALL register rom_data into note/duration, SHALL pulse new_note for 1 cycle, and SHALL move to WAIT_DONE.
REQ-020 Latency from FETCH entry to new_note SHALL be exactly 3 cycles.
REQ-021 WAIT_DONE SHALL hold until note_done=1, regardless of play; pausing is handled by the note player.
REQ-022 ADVANCE SHALL move to DONE if note_idx = NOTES_PER_SONG-1 (or on the end mark, REQ-031).
REQ-023 Otherwise ADVANCE SHALL increment note_idx and go to FETCH when play=1, else hold in ADVANCE.
REQ-024 DONE SHALL pulse song_done for 1 cycle, clear note_idx to 0, and return to IDLE.
REQ-025 note_idx SHALL never wrap silently; the only path from the last slot to 0 is through DONE.
REQ-026 reset_play SHALL take priority over every transition: state=IDLE, note_idx=0, new_note=0, song_done=0, note/duration=0, in the same edge.
REQ-027 reset_play coincident with note_done or song_done generation SHALL suppress ADVANCE/DONE; no song_done pulse shall be emitted.
REQ-028 song changes without reset_play SHALL take effect at the next FETCH only.

Reset
REQ-029 Asserting reset SHALL immediately force state=IDLE, note_idx=0, rom_addr={song,0}, note=0, duration=0, new_note=0, song_done=0.
REQ-030 After reset release, no output pulse SHALL occur until play=1.

Configuration
REQ-031 With SEQ_END_MARK_EN defined, a word with duration=0 loaded in LOAD SHALL NOT pulse new_note and SHALL go directly to DONE (song ends early).
REQ-032 Without SEQ_END_MARK_EN, duration=0 words SHALL be treated as ordinary notes, and songs always run NOTES_PER_SONG slots.

Structure
REQ-033 FSM state enum, ROM word field widths, and NOTES_PER_SONG default SHALL live in shared package music_pkg.
REQ-034 The note index counter SHALL be instantiated as the existing generic counter sub-module counter_n with enable and sync clear; the FSM stays in note_sequencer.

Verification
REQ-035 Reset release, play=1, ROM slot0={5,10}: rom_addr=0 at cycle 1; new_note pulses at cycle 3 with note=5, duration=10.
REQ-036 Play song 2 for 32 notes, pulsing note_done 4 cycles after each new_note: 32 new_note pulses, addresses 64..95; one song_done pulse after the 32nd note_done.
REQ-037 play=0 during WAIT_DONE of slot 3, note_done arrives: FSM holds in ADVANCE, no fetch; on play=1, rom_addr=slot 4 on the next cycle.
REQ-038 reset_play at slot 7 in the same cycle as note_done: state IDLE, note_idx=0, no song_done; next new_note carries slot 0.
REQ-039 With SEQ_END_MARK_EN, slot 4 duration=0: exactly 4 new_note pulses, then song_done; without it, slot 4 issues new_note with duration=0.
REQ-040 Async reset mid-LOAD: outputs zero immediately, before the next clk edge.
